digit_expander: RTL and testbench

Two-operand decimal fraction expander driven by the board's button/switch inputs, the counterpart of the fraction-reduction block. Where the reducer divides both digits by their common divisor, this block multiplies both digits by a user-entered factor. It produces two-digit BCD products by sequential repeated addition and presents them one BCD digit at a time on the same 4-bit display path. It sits between the debounced button inputs and the 7-segment digit driver.

---
 rtl/digit_expander_pkg.sv | 40 ++++
 rtl/digit_expander_edge_pulse.sv | 20 ++
 rtl/digit_expander.sv | 143 ++++++++++++++
 tb/tb_digit_expander.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_expander_pkg.sv
// Shared constants, state encoding and BCD helpers for the digit expander.
package digit_expander_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [1:0] ST_SETUP  = 2'd0;
    localparam logic [1:0] ST_FACTOR = 2'd1;
    localparam logic [1:0] ST_CALC   = 2'd2;
    localparam logic [1:0] ST_SHOW   = 2'd3;

    // Input is at most 9 + 15 = 24, so two conditional subtractions suffice.
    function automatic logic [DIGIT_W-1:0] mod10(input logic [DIGIT_W:0] v);
        logic [DIGIT_W:0] r;
        if (v >= 5'd20)
            r = v - 5'd20;
        else if (v >= 5'd10)
            r = v - 5'd10;
        else
            r = v;
        return r[DIGIT_W-1:0];
    endfunction

    function automatic logic [2*DIGIT_W-1:0] bcd_add(input logic [2*DIGIT_W-1:0] x,
                                                     input logic [DIGIT_W-1:0]   d);
        logic [DIGIT_W:0]     u;
        logic [DIGIT_W:0]     t;
        logic [2*DIGIT_W-1:0] r;
        u = {1'b0, x[3:0]} + {1'b0, d};
        t = u - 5'd10;
        if (u > 5'd9) begin
            r[3:0] = t[3:0];
            r[7:4] = x[7:4] + 4'd1;
        end else begin
            r[3:0] = u[3:0];
            r[7:4] = x[7:4];
        end
        return r;
    endfunction

endpackage

// File: rtl/digit_expander_edge_pulse.sv
// Rising-edge detector: one-cycle pulse on the first cycle the input is seen high.
module edge_pulse (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_in,
    output logic o_pulse
);

    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_prev <= 1'b0;
        else
            r_prev <= i_in;
    end

    assign o_pulse = i_in & ~r_prev;

endmodule

// File: rtl/digit_expander.sv
// Multiplies two BCD digits by a user factor via repeated addition and shows one digit at a time.
// Optional macro INPUT_SYNC_EN adds 2-flop synchronizers on add, next and select.
module digit_expander
    import digit_expander_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_select,
    input  logic               i_add,
    input  logic               i_next,
    input  logic [DIGIT_W-1:0] i_data_in,
    output logic [DIGIT_W-1:0] o_data_out,
    output logic               o_busy
);

    logic w_add_lvl, w_next_lvl, w_sel;
    logic w_add_p, w_next_p;

`ifdef INPUT_SYNC_EN
    logic [1:0] r_add_sync, r_next_sync, r_sel_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_add_sync  <= 2'b00;
            r_next_sync <= 2'b00;
            r_sel_sync  <= 2'b00;
        end else begin
            r_add_sync  <= {r_add_sync[0], i_add};
            r_next_sync <= {r_next_sync[0], i_next};
            r_sel_sync  <= {r_sel_sync[0], i_select};
        end
    end

    assign w_add_lvl  = r_add_sync[1];
    assign w_next_lvl = r_next_sync[1];
    assign w_sel      = r_sel_sync[1];
`else
    assign w_add_lvl  = i_add;
    assign w_next_lvl = i_next;
    assign w_sel      = i_select;
`endif

    edge_pulse u_add_pulse  (.i_clk(i_clk), .i_rst(i_rst), .i_in(w_add_lvl),  .o_pulse(w_add_p));
    edge_pulse u_next_pulse (.i_clk(i_clk), .i_rst(i_rst), .i_in(w_next_lvl), .o_pulse(w_next_p));

    logic [1:0]           r_state, w_state_nx;
    logic [DIGIT_W-1:0]   r_op [2];
    logic [DIGIT_W-1:0]   w_op_nx [2];
    logic [DIGIT_W-1:0]   r_k, w_k_nx;
    logic [DIGIT_W-1:0]   r_cnt, w_cnt_nx;
    logic [2*DIGIT_W-1:0] r_acc [2];
    logic [2*DIGIT_W-1:0] w_acc_nx [2];
    logic                 r_tens, w_tens_nx;
    logic [DIGIT_W-1:0]   r_data_out, w_data_nx;
    logic                 r_busy, w_busy_nx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_SETUP;
            r_op[0]    <= '0;
            r_op[1]    <= '0;
            r_k        <= '0;
            r_cnt      <= '0;
            r_acc[0]   <= '0;
            r_acc[1]   <= '0;
            r_tens     <= 1'b0;
            r_data_out <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_op       <= w_op_nx;
            r_k        <= w_k_nx;
            r_cnt      <= w_cnt_nx;
            r_acc      <= w_acc_nx;
            r_tens     <= w_tens_nx;
            r_data_out <= w_data_nx;
            r_busy     <= w_busy_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_op_nx    = r_op;
        w_k_nx     = r_k;
        w_cnt_nx   = r_cnt;
        w_acc_nx   = r_acc;
        w_tens_nx  = r_tens;
        case (r_state)
            ST_SETUP: begin
                if (w_add_p)
                    w_op_nx[w_sel] = mod10({1'b0, r_op[w_sel]} + {1'b0, i_data_in});
                if (w_next_p)
                    w_state_nx = ST_FACTOR;
            end
            ST_FACTOR: begin
                if (w_add_p)
                    w_k_nx = mod10({1'b0, r_k} + {1'b0, i_data_in});
                // The count starts from the factor including a same-cycle add.
                if (w_next_p) begin
                    w_state_nx  = ST_CALC;
                    w_cnt_nx    = w_k_nx;
                    w_acc_nx[0] = '0;
                    w_acc_nx[1] = '0;
                end
            end
            ST_CALC: begin
                if (r_cnt == '0) begin
                    w_state_nx = ST_SHOW;
                    w_tens_nx  = 1'b0;
                end else begin
                    w_acc_nx[0] = bcd_add(r_acc[0], r_op[0]);
                    w_acc_nx[1] = bcd_add(r_acc[1], r_op[1]);
                    w_cnt_nx    = r_cnt - 4'd1;
                end
            end
            ST_SHOW: begin
                if (w_next_p) begin
                    w_state_nx = ST_SETUP;
                    w_tens_nx  = 1'b0;
                end else if (w_add_p) begin
                    w_tens_nx = ~r_tens;
                end
            end
            default: w_state_nx = ST_SETUP;
        endcase
    end

    // Display follows the state being entered, so the digit is valid the cycle it appears.
    always_comb begin
        w_data_nx = '0;
        case (w_state_nx)
            ST_SETUP:  w_data_nx = w_op_nx[w_sel];
            ST_FACTOR: w_data_nx = w_k_nx;
            ST_SHOW:   w_data_nx = w_tens_nx ? w_acc_nx[w_sel][7:4] : w_acc_nx[w_sel][3:0];
            default:   w_data_nx = '0;
        endcase
        w_busy_nx = (w_state_nx == ST_CALC);
    end

    assign o_data_out = r_data_out;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_digit_expander.sv
// Bench for digit_expander: directed scenarios plus randomized sessions against a product-level model.
module tb_digit_expander;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic       add;
    logic       nxt;
    logic [3:0] din;
    logic [3:0] dout;
    logic       busy;

    always #5 clk = ~clk;

    digit_expander dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_select   (sel),
        .i_add      (add),
        .i_next     (nxt),
        .i_data_in  (din),
        .o_data_out (dout),
        .o_busy     (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    localparam int M_SETUP  = 0;
    localparam int M_FACTOR = 1;
    localparam int M_CALC   = 2;
    localparam int M_SHOW   = 3;

    int m_op [2];
    int m_k;
    int m_sel;
    int m_mode;
    bit m_tens;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_disp();
        int prod;
        case (m_mode)
            M_SETUP:  return m_op[m_sel];
            M_FACTOR: return m_k;
            M_SHOW: begin
                prod = m_op[m_sel] * m_k;
                return m_tens ? prod / 10 : prod % 10;
            end
            default:  return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_op[0] = 0;
        m_op[1] = 0;
        m_k     = 0;
        m_mode  = M_SETUP;
        m_tens  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        add = 1'b0;
        nxt = 1'b0;
        @(negedge clk);
        check("reset_dout", dout, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_calc();
        int cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            check("calc_dout", dout, 0);
            cycles++;
            @(negedge clk);
        end
        check("calc_len", cycles, m_k + 1);
        m_mode = M_SHOW;
        m_tens = 1'b0;
        check("show_entry", dout, exp_disp());
        check("show_busy", busy, 0);
    endtask

    task automatic do_press(input bit a, input bit n, input int d);
        @(negedge clk);
        din = d[3:0];
        add = a;
        nxt = n;
        @(negedge clk);
        add = 1'b0;
        nxt = 1'b0;
        case (m_mode)
            M_SETUP: begin
                if (a) m_op[m_sel] = (m_op[m_sel] + d) % 10;
                if (n) m_mode = M_FACTOR;
            end
            M_FACTOR: begin
                if (a) m_k = (m_k + d) % 10;
                if (n) m_mode = M_CALC;
            end
            M_SHOW: begin
                if (n) m_mode = M_SETUP;
                else if (a) m_tens = !m_tens;
            end
            default: ;
        endcase
        if (m_mode == M_CALC) begin
            check("enter_busy", busy, 1);
            check("enter_dout", dout, 0);
            wait_calc();
        end else begin
            check("press_dout", dout, exp_disp());
            check("press_busy", busy, 0);
        end
    endtask

    task automatic set_sel(input int s);
        @(negedge clk);
        sel = s[0];
        @(negedge clk);
        m_sel = s;
        check("sel_dout", dout, exp_disp());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        sel = 1'b0;
        add = 1'b0;
        nxt = 1'b0;
        din = 4'd0;
        m_sel = 0;
        model_reset();

        // 3 x 7 = 21 and 4 x 7 = 28
        do_reset();
        do_press(1, 0, 3);
        set_sel(1);
        do_press(1, 0, 4);
        do_press(0, 1, 0);
        do_press(1, 0, 7);
        do_press(0, 1, 0);
        set_sel(0);
        do_press(1, 0, 0);
        set_sel(1);
        do_press(1, 0, 0);
        do_press(0, 1, 0);

        // Wrap-around in SETUP
        do_reset();
        set_sel(0);
        do_press(1, 0, 7);
        do_press(1, 0, 5);
        set_sel(1);
        do_press(1, 0, 15);

        // Zero factor
        do_reset();
        set_sel(0);
        do_press(1, 0, 6);
        do_press(0, 1, 0);
        do_press(0, 1, 0);
        do_press(1, 0, 0);
        do_press(0, 1, 0);

        // Max product 9 x 9
        do_reset();
        do_press(1, 0, 9);
        set_sel(1);
        do_press(1, 0, 9);
        do_press(0, 1, 0);
        do_press(1, 0, 9);
        do_press(0, 1, 0);
        do_press(1, 0, 0);
        set_sel(0);
        do_press(1, 0, 0);
        do_press(0, 1, 0);

        // Add and next together in FACTOR
        do_reset();
        do_press(1, 0, 4);
        do_press(0, 1, 0);
        do_press(1, 1, 2);
        do_press(0, 1, 0);

        // Reset in the third CALC cycle
        do_reset();
        do_press(1, 0, 4);
        do_press(0, 1, 0);
        do_press(1, 0, 5);
        @(negedge clk);
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        check("abort_busy1", busy, 1);
        @(negedge clk);
        @(negedge clk);
        check("abort_busy3", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_dout", dout, 0);
        rst = 1'b0;
        model_reset();
        do_press(1, 0, 0);
        do_press(0, 1, 0);
        do_press(0, 1, 0);
        do_press(0, 1, 0);

        // Holding add counts once
        @(negedge clk);
        din = 4'd1;
        add = 1'b1;
        repeat (5) @(negedge clk);
        add = 1'b0;
        m_op[m_sel] = (m_op[m_sel] + 1) % 10;
        check("hold_dout", dout, exp_disp());
        @(negedge clk);
        check("hold_once", dout, exp_disp());

        // Randomized sessions
        for (int r = 0; r < 30; r++) begin
            repeat ($urandom_range(1, 4)) begin
                if ($urandom_range(0, 2) == 0) set_sel(int'($urandom_range(0, 1)));
                else do_press(1, 0, int'($urandom_range(0, 15)));
            end
            do_press(bit'($urandom_range(0, 1)), 1, int'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 3)) do_press(1, 0, int'($urandom_range(0, 15)));
            do_press(bit'($urandom_range(0, 1)), 1, int'($urandom_range(0, 15)));
            repeat ($urandom_range(1, 4)) begin
                if ($urandom_range(0, 1) == 0) set_sel(int'($urandom_range(0, 1)));
                else do_press(1, 0, int'($urandom_range(0, 15)));
            end
            do_press(bit'($urandom_range(0, 1)), 1, int'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
